// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier sequencer: one partial-product row per clock, WIDTH+1 edge latency.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: zero operands jump straight to DONE with product 0.
module seq_mult_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_p;
  logic [2*WIDTH-1:0]   r_product;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH-1:0]     w_pp;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_p_shift;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_zero_op;

  // One cell row: add the gated multiplicand into the upper half, shift right keeping the carry.
  assign w_pp      = r_p[0] ? r_mcand : '0;
  assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_pp};
  assign w_p_shift = {w_sum, r_p[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
  assign w_accept  = (r_state == S_IDLE) && in_valid;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign w_zero_op = (a == '0) || (b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_zero_op ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_p       <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mcand <= a;
        r_cnt   <= '0;
        if (w_zero_op) begin
          r_p       <= '0;
          r_product <= '0;
        end else begin
          r_p <= {{WIDTH{1'b0}}, b};
        end
      end else if (r_state == S_RUN) begin
        r_p   <= w_p_shift;
        r_cnt <= r_cnt + CNT_W'(1);
        // Product is captured once so it stays put through DONE and after returning to IDLE.
        if (w_last) r_product <= w_p_shift;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomized checks of seq_mult_ctrl (WIDTH=4) against an arithmetic reference.
module tb_seq_mult_ctrl;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_txn  = 0;
  int n_out  = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) n_out++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: product is the plain integer product; latency counted in edges after the accept edge.
  function automatic int exp_latency(input int av, input int bv);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    if (av == 0 || bv == 0) return 0;
`endif
    return W;
  endfunction

  task automatic do_txn(input int av, input int bv, input int stall, input bit hold_vld);
    int n;
    int exp_p;
    exp_p = av * bv;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) begin
      chk("wait_in_ready", {63'd0, in_ready}, 64'd1);
      return;
    end
    a = W'(av); b = W'(bv); in_valid = 1'b1;
    out_ready = (stall == 0);
    step();
    chk("acc_in_ready", {63'd0, in_ready}, 64'd0);
    chk("acc_busy", {63'd0, busy}, 64'd1);
    if (!hold_vld) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("latency", 64'(n), 64'(exp_latency(av, bv)));
    chk("product", 64'(product), 64'(exp_p));
    for (int s = 0; s < stall; s++) begin
      if (!hold_vld) begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
      end
      step();
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_product", 64'(product), 64'(exp_p));
      chk("stall_busy", {63'd0, busy}, 64'd1);
    end
    if (!hold_vld) in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("exit_out_valid", {63'd0, out_valid}, 64'd0);
    chk("exit_in_ready", {63'd0, in_ready}, 64'd1);
    chk("exit_busy", {63'd0, busy}, 64'd0);
    chk("exit_product_hold", 64'(product), 64'(exp_p));
    n_txn++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    step();

    do_txn(13, 11, 0, 1'b0);
    do_txn(15, 15, 5, 1'b0);
    do_txn(0, 7, 0, 1'b0);

    a = 4'd9; b = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_run_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_product", 64'(product), 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #2 rst_n = 1'b1;
    step();
    do_txn(9, 6, 0, 1'b0);

    do_txn(3, 5, 0, 1'b1);
    do_txn(12, 10, 0, 1'b1);
    do_txn(1, 15, 0, 1'b1);
    in_valid = 1'b0;
    step();

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_txn(i, j, int'($urandom_range(0, 3)), 1'b0);

    step();
    chk("result_count", 64'(n_out), 64'(n_txn));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
